// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, scan FSM encoding and a window-compare helper
// for the VGA scan path.
package vga_timing_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;
   localparam int CLK_DIV_DEF  = 4;

   localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_SCAN  = 2'd2,
      ST_DRAIN = 2'd3
   } scan_state_t;

   // Half-open window lo <= pos < hi on an unsigned 10-bit position.
   function automatic logic in_window(input logic [9:0] pos,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
      return (pos >= lo) && (pos < hi);
   endfunction

endpackage

// File: rtl/vga_phase_decode.sv
// Maps one scan coordinate onto its active and sync phases; used once for the
// horizontal axis and once for the vertical axis.
module vga_phase_decode
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = H_ACTIVE_DEF,
   parameter int FP     = H_FP_DEF,
   parameter int SYNC   = H_SYNC_DEF
)(
   input  logic [9:0] pos,
   output logic       active,
   output logic       sync_region
);

   localparam logic [9:0] ACTIVE_END = 10'(ACTIVE);
   localparam logic [9:0] SYNC_START = 10'(ACTIVE + FP);
   localparam logic [9:0] SYNC_END   = 10'(ACTIVE + FP + SYNC);

   assign active      = (pos < ACTIVE_END);
   assign sync_region = in_window(pos, SYNC_START, SYNC_END);

endmodule

// File: rtl/vga_scan_sequencer.sv
// VGA scan controller: pixel-rate divider, horizontal counter, run/stop FSM that
// steps an external vertical counter, registered sync/video decode and desync flag.
module vga_scan_sequencer
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = H_ACTIVE_DEF,
   parameter int   H_FP     = H_FP_DEF,
   parameter int   H_SYNC   = H_SYNC_DEF,
   parameter int   H_BP     = H_BP_DEF,
   parameter int   V_ACTIVE = V_ACTIVE_DEF,
   parameter int   V_FP     = V_FP_DEF,
   parameter int   V_SYNC   = V_SYNC_DEF,
   parameter int   V_BP     = V_BP_DEF,
   parameter int   CLK_DIV  = CLK_DIV_DEF,
   parameter logic SYNC_POL = 1'b0
)(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       run,
   input  logic [9:0] v_pixel_y,
   input  logic       v_done_y,
   output logic       v_enable,
   output logic       pixel_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       frame_start,
   output logic       err_desync
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = $clog2(CLK_DIV);

   localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]       V_LIMIT  = 10'(V_TOTAL);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   scan_state_t      state, state_next;
   logic [DIV_W-1:0] div_cnt;
   logic             scanning, line_end, y_mismatch;
   logic             h_active, h_sync, v_active, v_sync;

   assign scanning   = (state == ST_SCAN) || (state == ST_DRAIN);
   assign pixel_tick = scanning && (div_cnt == DIV_LAST);
   assign line_end   = pixel_tick && (pixel_x == H_LAST);
   assign y_mismatch = (v_done_y != (v_pixel_y == V_LAST)) || (v_pixel_y >= V_LIMIT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   // ALIGN steps the vertical counter every clk so it wraps to 0 as SCAN begins;
   // DRAIN only leaves on the line that carries the vertical wrap.
   always_comb begin
      state_next = state;
      v_enable   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (run) state_next = (v_pixel_y == 10'd0) ? ST_SCAN : ST_ALIGN;
         end
         ST_ALIGN: begin
            v_enable = 1'b1;
            if (v_done_y) state_next = ST_SCAN;
         end
         ST_SCAN: begin
            v_enable = line_end;
            if (!run) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            v_enable = line_end;
            if (run)                       state_next = ST_SCAN;
            else if (line_end && v_done_y) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                  div_cnt <= '0;
      else if (!scanning)            div_cnt <= '0;
      else if (div_cnt == DIV_LAST)  div_cnt <= '0;
      else                           div_cnt <= div_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        pixel_x <= '0;
      else if (!scanning)  pixel_x <= '0;
      else if (pixel_tick) pixel_x <= (pixel_x == H_LAST) ? 10'd0 : pixel_x + 10'd1;
   end

   vga_phase_decode #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC)) u_h_decode (
      .pos         (pixel_x),
      .active      (h_active),
      .sync_region (h_sync)
   );

   vga_phase_decode #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC)) u_v_decode (
      .pos         (v_pixel_y),
      .active      (v_active),
      .sync_region (v_sync)
   );

   // The external counter already moves on the same edge as pixel_x, so the
   // decode uses v_pixel_y directly and every decoded output lags by one clk.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pixel_y     <= '0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         video_on    <= 1'b0;
         frame_start <= 1'b0;
         err_desync  <= 1'b0;
      end else begin
         pixel_y     <= v_pixel_y;
         hsync       <= (scanning && h_sync) ? SYNC_POL : ~SYNC_POL;
         vsync       <= (scanning && v_sync) ? SYNC_POL : ~SYNC_POL;
         video_on    <= scanning && h_active && v_active;
         frame_start <= pixel_tick && (pixel_x == 10'd0) && (v_pixel_y == 10'd0);
         if (pixel_tick && y_mismatch) err_desync <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vga_scan_sequencer.sv
// Directed bench for vga_scan_sequencer on a shrunken 16x11-pixel raster with a
// behavioural vertical counter sharing the design's reset.
module tb_vga_scan_sequencer;

   // Raster: H 8/2/3/3 (total 16, hsync x=10..12), V 6/1/2/2 (total 11, vsync y=7..8)
   localparam int H_TOTAL = 16;
   localparam int V_TOTAL = 11;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       run;
   logic [9:0] vy;
   logic       v_done_y;
   logic       force_done;
   logic       preload;
   logic [9:0] preload_val;
   logic       v_enable, pixel_tick, hsync, vsync, video_on, frame_start, err_desync;
   logic [9:0] pixel_x, pixel_y;

   int check_count = 0;
   int error_count = 0;

   logic measure = 1'b0;
   int   cyc, last_fs, last_ve, fs_interval, ve_interval, vid_acc, vid_frame;
   int   h_min, h_max, v_min, v_max, prev_x, prev_y;

   vga_scan_sequencer #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .CLK_DIV(4),  .SYNC_POL(1'b0)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .run         (run),
      .v_pixel_y   (vy),
      .v_done_y    (v_done_y),
      .v_enable    (v_enable),
      .pixel_tick  (pixel_tick),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .hsync       (hsync),
      .vsync       (vsync),
      .video_on    (video_on),
      .frame_start (frame_start),
      .err_desync  (err_desync)
   );

   always #5 clk = ~clk;

   // External vertical counter, stepped by v_enable and reset with the design
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)      vy <= '0;
      else if (preload)  vy <= preload_val;
      else if (v_enable) vy <= (vy == 10'(V_TOTAL - 1)) ? 10'd0 : vy + 10'd1;
   end

   assign v_done_y = (vy == 10'(V_TOTAL - 1)) || force_done;

   // Steady-state raster statistics gathered at every falling edge
   always @(negedge clk) begin
      if (!measure) begin
         cyc = 0; last_fs = -1; last_ve = -1; fs_interval = 0; ve_interval = 0;
         vid_acc = 0; vid_frame = 0; h_min = 1023; h_max = 0; v_min = 1023; v_max = 0;
      end else begin
         cyc++;
         if (frame_start) begin
            if (last_fs >= 0) begin
               fs_interval = cyc - last_fs;
               vid_frame   = vid_acc;
            end
            last_fs = cyc;
            vid_acc = 0;
         end
         if (video_on) vid_acc++;
         if (v_enable) begin
            if (last_ve >= 0) ve_interval = cyc - last_ve;
            last_ve = cyc;
         end
         if (!hsync) begin
            if (prev_x < h_min) h_min = prev_x;
            if (prev_x > h_max) h_max = prev_x;
         end
         if (!vsync) begin
            if (prev_y < v_min) v_min = prev_y;
            if (prev_y > v_max) v_max = prev_y;
         end
      end
      prev_x = int'(pixel_x);
      prev_y = int'(vy);
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic run_val, input logic reset_val);
      @(negedge clk);
      run     = run_val;
      reset_n = reset_val;
   endtask

   // Counts falling edges until the first pixel_tick, bounded
   task automatic countToFirstTick(output int n);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (pixel_tick) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic waitForY(input int y, input int limit, output int found);
      found = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (int'(vy) == y) begin
            found = 1;
            break;
         end
      end
   endtask

   initial begin
      int n, found, ve_cnt, last_ve_y, last_ve_x, idle_run, align_pulses;

      reset_n = 1'b0; run = 1'b0; force_done = 1'b0; preload = 1'b0; preload_val = '0;
      #12;
      checkOutput("rst_pixel_x",     int'(pixel_x),     0);
      checkOutput("rst_pixel_tick",  int'(pixel_tick),  0);
      checkOutput("rst_v_enable",    int'(v_enable),    0);
      checkOutput("rst_hsync",       int'(hsync),       1);
      checkOutput("rst_vsync",       int'(vsync),       1);
      checkOutput("rst_video_on",    int'(video_on),    0);
      checkOutput("rst_frame_start", int'(frame_start), 0);
      checkOutput("rst_err_desync",  int'(err_desync),  0);

      applyStimulus(1'b0, 1'b1);
      repeat (3) @(negedge clk);
      checkOutput("idle_tick", int'(pixel_tick), 0);
      checkOutput("idle_hsync", int'(hsync), 1);

      // Start at y=0: straight into SCAN, first tick four clocks later
      $display("[TB] start from y=0");
      applyStimulus(1'b1, 1'b1);
      measure = 1'b1;
      countToFirstTick(n);
      checkOutput("first_tick_clk", n, 4);
      @(negedge clk);
      checkOutput("x_after_first_tick", int'(pixel_x), 1);

      repeat (2300) @(negedge clk);
      checkOutput("frame_interval", fs_interval, H_TOTAL * V_TOTAL * 4);
      checkOutput("line_interval",  ve_interval, H_TOTAL * 4);
      checkOutput("hsync_first_x",  h_min, 10);
      checkOutput("hsync_last_x",   h_max, 12);
      checkOutput("vsync_first_y",  v_min, 7);
      checkOutput("vsync_last_y",   v_max, 8);
      checkOutput("video_on_clks",  vid_frame, 8 * 6 * 4);
      checkOutput("no_desync",      int'(err_desync), 0);
      measure = 1'b0;

      // Stop request mid-frame: finish frame, final wrap pulse, then idle
      $display("[TB] drain from y=3");
      waitForY(2, 1000, found);
      checkOutput("drain_wait_y2", found, 1);
      waitForY(3, 100, found);
      checkOutput("drain_wait_y3", found, 1);
      run = 1'b0;
      ve_cnt = 0; last_ve_y = -1; last_ve_x = -1; idle_run = 0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if (v_enable) begin
            ve_cnt++;
            last_ve_y = int'(vy);
            last_ve_x = int'(pixel_x);
         end
         if (pixel_tick) idle_run = 0;
         else            idle_run++;
         if (idle_run >= 12) break;
      end
      checkOutput("drain_reached_idle", int'(idle_run >= 12), 1);
      checkOutput("drain_pulses",  ve_cnt, 8);
      checkOutput("drain_final_y", last_ve_y, V_TOTAL - 1);
      checkOutput("drain_final_x", last_ve_x, H_TOTAL - 1);
      checkOutput("idle_y",        int'(vy), 0);
      checkOutput("idle_x",        int'(pixel_x), 0);
      checkOutput("idle_hsync_hi", int'(hsync), 1);
      checkOutput("idle_vsync_hi", int'(vsync), 1);
      checkOutput("idle_video",    int'(video_on), 0);

      // Start with the vertical counter at y=7: four align pulses (7..10)
      $display("[TB] align from y=7");
      @(negedge clk);
      preload_val = 10'd7;
      preload     = 1'b1;
      @(negedge clk);
      preload = 1'b0;
      run     = 1'b1;
      align_pulses = 0;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (v_enable) align_pulses++;
         if (pixel_tick) begin
            n = i;
            break;
         end
      end
      checkOutput("align_pulses",  align_pulses, 4);
      checkOutput("align_tick_clk", n, 8);
      checkOutput("align_scan_y",  int'(vy), 0);
      checkOutput("align_scan_x",  int'(pixel_x), 0);

      // Forced terminal flag off the last line sets the sticky desync error
      $display("[TB] desync injection at y=5");
      waitForY(5, 1000, found);
      checkOutput("desync_wait_y5", found, 1);
      checkOutput("desync_before", int'(err_desync), 0);
      force_done = 1'b1;
      found = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (pixel_tick) begin
            found = 1;
            break;
         end
      end
      checkOutput("desync_tick_seen", found, 1);
      @(negedge clk);
      force_done = 1'b0;
      checkOutput("desync_set", int'(err_desync), 1);
      repeat (200) @(negedge clk);
      checkOutput("desync_sticky", int'(err_desync), 1);

      // Asynchronous reset in the middle of line 3, pixel 6
      $display("[TB] async reset mid-frame");
      found = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (int'(vy) == 3 && int'(pixel_x) == 6) begin
            found = 1;
            break;
         end
      end
      checkOutput("rst_wait_pos", found, 1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("mid_rst_x",        int'(pixel_x),     0);
      checkOutput("mid_rst_y",        int'(pixel_y),     0);
      checkOutput("mid_rst_vy",       int'(vy),          0);
      checkOutput("mid_rst_tick",     int'(pixel_tick),  0);
      checkOutput("mid_rst_v_enable", int'(v_enable),    0);
      checkOutput("mid_rst_hsync",    int'(hsync),       1);
      checkOutput("mid_rst_vsync",    int'(vsync),       1);
      checkOutput("mid_rst_video",    int'(video_on),    0);
      checkOutput("mid_rst_err",      int'(err_desync),  0);
      applyStimulus(1'b1, 1'b1);
      countToFirstTick(n);
      checkOutput("restart_tick_clk", n, 4);
      repeat (800) @(negedge clk);
      checkOutput("restart_no_desync", int'(err_desync), 0);

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
